// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_adder_pkg;

  // Default operand width in bits.
  localparam int DEF_WIDTH = 8;

  // Two-bit FSM encoding; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width for an n-bit operand. The extra bit keeps n = 2^k safe.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fadder.sv
// One-bit full adder cell: s = x ^ y ^ z, c = majority(x, y, z).
// Latency: combinational.
// Backpressure: none.
module fadder (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y,
  input  logic z
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one fadder and a carry flop, LSB first, one bit per clock.
// Latency: N+1 cycles from the accepted start edge to the done cycle.
// Backpressure: start is ignored while busy; start during the done cycle chains the next op.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           r_state;
  logic [N-1:0]     r_sh_a;
  logic [N-1:0]     r_sh_b;
  logic [N-1:0]     r_psum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic [N-1:0]     w_psum_next;

  // The single full-adder slice sees the current LSBs and the running carry.
  fadder u_fadder (
    .s (w_s),
    .c (w_c),
    .x (r_sh_a[0]),
    .y (r_sh_b[0]),
    .z (r_carry)
  );

  // Each new sum bit enters at the MSB, so after N shifts bit 0 holds the first result.
  assign w_psum_next = {w_s, r_psum[N-1:1]};

  // Sequencer: operand capture, per-bit shifting, and result commit on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sh_a  <= a;
            r_sh_b  <= b;
            r_psum  <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sh_a  <= {1'b0, r_sh_a[N-1:1]};
          r_sh_b  <= {1'b0, r_sh_b[N-1:1]};
          r_psum  <= w_psum_next;
          r_carry <= w_c;
          if (r_cnt == CNT_LAST) begin
            // Last bit: publish the result; the counter stays at N-1 rather than wrapping.
            r_sum   <= w_psum_next;
            r_cout  <= w_c;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags are pure decodes of the registered state, so no input reaches an output.
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       busy;
  logic       done;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic [3:0] sum4;
  logic       cout4;
  logic       busy4;
  logic       done4;

  int checks;
  int failures;

  serial_adder #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  serial_adder #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .sum   (sum4),
    .cout  (cout4),
    .busy  (busy4),
    .done  (done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an op on the 8-bit DUT from a negedge and returns at the negedge where done is seen.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     output int lat, output int busy_n);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = tb ^ 8'h5A; cin = ~tc;
    lat = 0; busy_n = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) break;
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     output int lat);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = ~ta; b4 = ~tb; cin4 = ~tc;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done4) break;
    end
  endtask

  initial begin
    int lat;
    int bn;
    int ndone;
    int hold_bad;
    int exp_val;

    checks = 0; failures = 0;
    rst = 1'b1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

    #1;
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_sum4", 32'(sum4), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 5A + 3C
    op8(8'h5A, 8'h3C, 1'b0, lat, bn);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(bn), 32'd8);
    chk("t1_sum", 32'(sum), 32'h96);
    chk("t1_cout", 32'(cout), 32'h0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // FF + 01 wraps
    op8(8'hFF, 8'h01, 1'b0, lat, bn);
    chk("t2a_sum", 32'(sum), 32'h00);
    chk("t2a_cout", 32'(cout), 32'h1);
    @(negedge clk);
    op8(8'hFF, 8'hFF, 1'b1, lat, bn);
    chk("t2b_sum", 32'(sum), 32'hFF);
    chk("t2b_cout", 32'(cout), 32'h1);
    @(negedge clk);

    // 01 + 01 with a stray start in RUN cycle 3
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0; ndone = 0; hold_bad = 0;
    while (lat < 30 && ndone == 0) begin
      @(negedge clk);
      lat++;
      if (done) ndone++;
      else if (sum !== 8'hFF || cout !== 1'b1) hold_bad++;
      if (lat == 3) begin
        a = 8'hAA; b = 8'hAA; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk("t3_latency", 32'(lat), 32'd9);
    chk("t3_hold_prior", 32'(hold_bad), 32'd0);
    chk("t3_sum", 32'(sum), 32'h02);
    chk("t3_cout", 32'(cout), 32'h0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t3_single_done", 32'(ndone), 32'd0);

    // 10 + 20 aborted by reset in RUN cycle 4
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("t4_busy_before_rst", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_rst_sum", 32'(sum), 32'h0);
    chk("t4_rst_cout", 32'(cout), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_no_done", 32'(ndone), 32'd0);
    op8(8'h10, 8'h20, 1'b0, lat, bn);
    chk("t4_fresh_latency", 32'(lat), 32'd9);
    chk("t4_fresh_sum", 32'(sum), 32'h30);
    @(negedge clk);

    // Back-to-back: second start presented in the DONE cycle
    op8(8'h0F, 8'h01, 1'b0, lat, bn);
    chk("t5a_sum", 32'(sum), 32'h10);
    chk("t5a_cout", 32'(cout), 32'h0);
    op8(8'h80, 8'h80, 1'b0, lat, bn);
    chk("t5b_latency", 32'(lat), 32'd9);
    chk("t5b_busy_cycles", 32'(bn), 32'd8);
    chk("t5b_sum", 32'(sum), 32'h00);
    chk("t5b_cout", 32'(cout), 32'h1);
    @(negedge clk);

    // N=4 exhaustive, chained through the DONE cycle
    for (int i = 0; i < 512; i++) begin
      op4(4'(i), 4'(i >> 4), 1'(i >> 8), lat);
      exp_val = (i & 15) + ((i >> 4) & 15) + ((i >> 8) & 1);
      chk("n4_result", {27'd0, cout4, sum4}, 32'(exp_val));
      chk("n4_latency", 32'(lat), 32'd5);
    end
    @(negedge clk);
    chk("n4_final_idle", 32'(busy4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
